fir_out_buffer: RTL and testbench
=================================

// Module: fir_out_buffer
// PURPOSE
//  Downstream stage of the FIR filter: captures each 16-bit FIR result presented with out_enable,
//  rounds/scales it to OUT_W bits with saturation, and buffers it in a small FIFO.
//  Results leave on a valid/ready port, so a slow consumer never has to track FIR timing.
//  Also latches the FIR error line and buffer overflow as sticky status flags.
// PARAMETERS
//  IN_W   16  width of FIR result (fir_data)
//  OUT_W  8   width of scaled output word
//  SHIFT  2   right-shift applied after rounding (0..IN_W-1); 0 = no rounding
//  DEPTH  4   FIFO entries; power of two, >= 2
// PORTS
//  clk             in   1                   clock, all state on rising edge
//  reset           in   1                   synchronous, active-high reset
//  fir_data        in   IN_W                FIR result (unsigned)
//  fir_out_enable  in   1                   result valid this cycle; one capture per high cycle
//  fir_error       in   1                   FIR error indication
//  clear_flags     in   1                   clears overflow and fir_error_latched
//  m_data          out  OUT_W               head-of-FIFO word
//  m_valid         out  1                   FIFO non-empty
//  m_ready         in   1                   consumer accepts m_data when m_valid & m_ready
//  level           out  $clog2(DEPTH)+1     number of stored words
//  overflow        out  1                   sticky: a result was dropped
//  fir_error_latched out 1                  sticky: fir_error seen high
// BEHAVIOUR
//  - Reset (sync, active-high): rd/wr pointers 0, level 0, m_valid 0, overflow 0,
//    fir_error_latched 0; FIFO contents discarded. Reset mid-stream drops everything; m_valid 0 after that edge.
//  - Scaling (combinational): t = fir_data + (SHIFT>0 ? 1<<(SHIFT-1) : 0), computed IN_W+1 bits;
//    s = t >> SHIFT; out = (s > 2^OUT_W-1) ? 2^OUT_W-1 : s[OUT_W-1:0].
//  - Write: on edge where fir_out_enable=1 and (level<DEPTH or pop this cycle): mem[wr_ptr]<=out, wr_ptr++.
//  - Pop: on edge where m_valid & m_ready: rd_ptr++.
//  - Latency: result written at edge N is on m_data with m_valid=1 after edge N (1 cycle).
//  - level: +1 on write-only, -1 on pop-only, unchanged on both or neither.
//  - Full + push + pop same edge: write accepted, level stays DEPTH, no overflow.
//  - Full + push, no pop: word dropped, contents unchanged, overflow<=1.
//  - Empty + push + m_ready: no bypass; word is popped on a later edge.
//  - Pointers wrap modulo DEPTH (natural wrap of $clog2(DEPTH)-bit counters).
//  - m_data = mem[rd_ptr]; stable while m_valid & !m_ready; undefined when m_valid=0.
//  - fir_error=1 at an edge sets fir_error_latched.
//  - clear_flags clears both sticky flags; a set event in the same cycle wins (flag stays 1).
// STRUCTURE
//  - Shared package fir_pkg: FIR_DATA_W=16, FIR_SAMPLE_W=8 constants, used for IN_W default.
//  - One sub-module: fir_out_scale (combinational round/shift/saturate, params IN_W/OUT_W/SHIFT).
//  - FIFO storage, pointers, level and flags live in fir_out_buffer itself.
// TESTING (DEPTH=4, OUT_W=8, SHIFT=2)
//  1 Scaling: push 100, 6, 5, 1023 with m_ready=1 -> pops 25, 2, 1, 255 (saturated); overflow=0.
//  2 Fill/overflow: m_ready=0, push 4,8,12,16,20 -> level=4, overflow=1; drain -> 1,2,3,4; level=0, m_valid=0.
//  3 Full simultaneous: level=4, m_ready=1, push 40 same edge -> level stays 4, overflow=0; tail word later pops 10.
//  4 Wrap: stream 12 pushes of 4*k (k=1..12) with m_ready=1 -> pops 1..12 in order, level<=1 throughout.
//  5 Flags: fir_error pulse 1 cycle -> fir_error_latched=1 and held; clear_flags -> 0;
//    clear_flags and fir_error on same edge -> stays 1.
//  6 Reset mid-op: level=3, assert reset 1 cycle -> level=0, m_valid=0, flags 0; next push 100 -> pops 25.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR width constants
package fir_pkg;
  localparam int FIR_DATA_W   = 16;
  localparam int FIR_SAMPLE_W = 8;
endpackage

// File: rtl/fir_out_buffer_if.sv
// rtl/fir_out_buffer_if.sv - valid/ready result stream leaving the FIR output buffer
interface fir_out_buffer_if #(
  parameter int OUT_W = fir_pkg::FIR_SAMPLE_W
);
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fir_out_scale.sv
// rtl/fir_out_scale.sv - round, right-shift and saturate a FIR result
module fir_out_scale
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_DATA_W,
  parameter int OUT_W = FIR_SAMPLE_W,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data
);
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND = (SHIFT > 0) ? ((IN_W + 1)'(1) << RND_POS) : '0;
  localparam logic [IN_W:0] MAX_OUT = (IN_W + 1)'((64'(1) << OUT_W) - 64'(1));

  logic [IN_W:0] w_t;
  logic [IN_W:0] w_s;

  // One extra bit keeps the rounding carry from wrapping before the shift.
  always_comb begin
    w_t = {1'b0, i_data} + RND;
    w_s = w_t >> SHIFT;
    o_data = (w_s > MAX_OUT) ? {OUT_W{1'b1}} : w_s[OUT_W-1:0];
  end
endmodule

// File: rtl/fir_out_buffer.sv
// rtl/fir_out_buffer.sv - scale FIR results into a small FIFO with sticky status flags
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_DATA_W,
  parameter int OUT_W = FIR_SAMPLE_W,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_W-1:0]            fir_data,
  input  logic                       fir_out_enable,
  input  logic                       fir_error,
  input  logic                       clear_flags,
  fir_out_buffer_if.master           m_if,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       fir_error_latched
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_err;

  logic [OUT_W-1:0] w_scaled;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  fir_out_scale #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_scale (
    .i_data (fir_data),
    .o_data (w_scaled)
  );

  // A full FIFO still accepts a write when the head leaves on the same edge.
  always_comb begin
    w_full  = (r_level == LW'(DEPTH));
    w_empty = (r_level == '0);
    w_pop   = !w_empty && m_if.m_ready;
    w_push  = fir_out_enable && (!w_full || w_pop);
    w_drop  = fir_out_enable && w_full && !w_pop;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage carries no reset; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_scaled;
  end

  // Sticky flags: a set event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_overflow <= w_drop || (r_overflow && !clear_flags);
      r_err      <= fir_error || (r_err && !clear_flags);
    end
  end

  // Head-of-FIFO presentation; no bypass, so data appears one edge after the write.
  always_comb begin
    m_if.m_data       = r_mem[r_rd_ptr];
    m_if.m_valid      = !w_empty;
    level             = r_level;
    overflow          = r_overflow;
    fir_error_latched = r_err;
  end
endmodule

// File: tb/tb_fir_out_buffer.sv
// tb/tb_fir_out_buffer.sv - directed self-checking bench for fir_out_buffer
module tb_fir_out_buffer;
  import fir_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] fir_data = '0;
  logic        fir_out_enable = 1'b0;
  logic        fir_error = 1'b0;
  logic        clear_flags = 1'b0;
  logic [2:0]  level;
  logic        overflow;
  logic        fir_error_latched;

  int n_tests = 0;
  int n_fail  = 0;
  int got_q[$];
  int max_level;

  fir_out_buffer_if #(.OUT_W(8)) u_if ();

  fir_out_buffer #(
    .IN_W  (16),
    .OUT_W (8),
    .SHIFT (2),
    .DEPTH (4)
  ) u_dut (
    .clk               (clk),
    .reset             (reset),
    .fir_data          (fir_data),
    .fir_out_enable    (fir_out_enable),
    .fir_error         (fir_error),
    .clear_flags       (clear_flags),
    .m_if              (u_if.master),
    .level             (level),
    .overflow          (overflow),
    .fir_error_latched (fir_error_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Record a pop if one happens at the coming edge, then advance past it.
  task automatic cycle();
    if (u_if.m_valid === 1'b1 && u_if.m_ready === 1'b1 && reset === 1'b0)
      got_q.push_back(int'(u_if.m_data));
    @(posedge clk);
    #1;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic push(input int v);
    fir_data = 16'(v);
    fir_out_enable = 1'b1;
    cycle();
    fir_out_enable = 1'b0;
  endtask

  task automatic drain(input string tag);
    u_if.m_ready = 1'b1;
    for (int i = 0; i < 20 && u_if.m_valid === 1'b1; i++) cycle();
    check({tag, "_empty_valid"}, int'(u_if.m_valid), 0);
    check({tag, "_empty_level"}, int'(level), 0);
  endtask

  task automatic check_pops(input string tag, input int exp[$]);
    check({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s_pop%0d", tag, i), got_q[i], exp[i]);
    got_q.delete();
  endtask

  initial begin
    u_if.m_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(u_if.m_valid), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_err", int'(fir_error_latched), 0);

    // 1 scaling with saturation
    u_if.m_ready = 1'b1;
    push(100); push(6); push(5); push(1023);
    drain("t1");
    check_pops("t1", '{25, 2, 1, 255});
    check("t1_ovf", int'(overflow), 0);

    // 2 fill and overflow
    u_if.m_ready = 1'b0;
    push(4); push(8); push(12); push(16); push(20);
    check("t2_level", int'(level), 4);
    check("t2_ovf", int'(overflow), 1);
    drain("t2");
    check_pops("t2", '{1, 2, 3, 4});
    clear_flags = 1'b1; cycle(); clear_flags = 1'b0;
    check("t2_ovf_clr", int'(overflow), 0);

    // 3 full with simultaneous push and pop
    u_if.m_ready = 1'b0;
    push(4); push(8); push(12); push(16);
    check("t3_full", int'(level), 4);
    u_if.m_ready = 1'b1;
    push(40);
    check("t3_level", int'(level), 4);
    check("t3_ovf", int'(overflow), 0);
    drain("t3");
    check_pops("t3", '{1, 2, 3, 4, 10});

    // 4 streaming across pointer wrap
    u_if.m_ready = 1'b1;
    max_level = 0;
    for (int k = 1; k <= 12; k++) push(4 * k);
    drain("t4");
    check("t4_maxlvl", max_level, 1);
    check_pops("t4", '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12});

    // 5 sticky error flag
    fir_error = 1'b1; cycle(); fir_error = 1'b0;
    check("t5_set", int'(fir_error_latched), 1);
    cycle(); cycle();
    check("t5_hold", int'(fir_error_latched), 1);
    clear_flags = 1'b1; cycle(); clear_flags = 1'b0;
    check("t5_clr", int'(fir_error_latched), 0);
    fir_error = 1'b1; clear_flags = 1'b1; cycle();
    fir_error = 1'b0; clear_flags = 1'b0;
    check("t5_setwins", int'(fir_error_latched), 1);

    // 6 reset mid-operation
    u_if.m_ready = 1'b0;
    push(4); push(8); push(12);
    check("t6_level3", int'(level), 3);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("t6_level", int'(level), 0);
    check("t6_valid", int'(u_if.m_valid), 0);
    check("t6_ovf", int'(overflow), 0);
    check("t6_err", int'(fir_error_latched), 0);
    got_q.delete();
    u_if.m_ready = 1'b1;
    push(100);
    check("t6_lat_valid", int'(u_if.m_valid), 1);
    drain("t6");
    check_pops("t6", '{25});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
